// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU arbiter: FSM encoding, ALU FunSel codes and
// ZCNO flag positions.
package alu_arb_pkg;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned FS_W   = 4;
    localparam int unsigned FLAG_W = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    localparam logic [3:0] FS_A   = 4'b0000;
    localparam logic [3:0] FS_ADD = 4'b0100;
    localparam logic [3:0] FS_SUB = 4'b0101;
    localparam logic [3:0] FS_CMP = 4'b0110;
    localparam logic [3:0] FS_CSR = 4'b1111;

    localparam int unsigned ZCNO_Z = 3;
    localparam int unsigned ZCNO_C = 2;
    localparam int unsigned ZCNO_N = 1;
    localparam int unsigned ZCNO_O = 0;

    function automatic logic [1:0] id_to_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-side signals of the shared-ALU arbiter.
// slave = arbiter side, master = clients plus the ALU.
interface alu_arbiter_if;
    import alu_arb_pkg::*;

    logic [1:0]                   req_valid;
    logic [1:0]                   req_ready;
    logic [1:0]                   req_lock;
    logic [1:0][FS_W-1:0]         req_funsel;
    logic [1:0][DATA_W-1:0]       req_a;
    logic [1:0][DATA_W-1:0]       req_b;

    logic                         rsp_valid;
    logic                         rsp_id;
    logic [DATA_W-1:0]            rsp_data;
    logic [FLAG_W-1:0]            rsp_zcno;
    logic                         rsp_ready;

    logic [DATA_W-1:0]            alu_a;
    logic [DATA_W-1:0]            alu_b;
    logic [FS_W-1:0]              alu_funsel;
    logic [DATA_W-1:0]            alu_out;
    logic [FLAG_W-1:0]            alu_zcno;

    modport slave (
        input  req_valid, req_lock, req_funsel, req_a, req_b, rsp_ready,
               alu_out, alu_zcno,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_zcno,
               alu_a, alu_b, alu_funsel
    );

    modport master (
        output req_valid, req_lock, req_funsel, req_a, req_b, rsp_ready,
               alu_out, alu_zcno,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_zcno,
               alu_a, alu_b, alu_funsel
    );
endinterface

// File: rtl/alu_arb_rr.sv
// Two-way round-robin picker. A held lock restricts the grant to the owner
// while the owner is still requesting; otherwise plain alternation.
module alu_arb_rr
    import alu_arb_pkg::*;
(
    input  logic [1:0] valid_i,
    input  logic       last_i,
    input  logic       lock_i,
    input  logic       owner_i,
    output logic [1:0] grant_o,
    output logic       id_o
);
    always_comb begin
        grant_o = 2'b00;
        id_o    = 1'b0;
        if (lock_i && valid_i[owner_i]) begin
            id_o    = owner_i;
            grant_o = id_to_onehot(owner_i);
        end else if (valid_i == 2'b11) begin
            id_o    = ~last_i;
            grant_o = id_to_onehot(~last_i);
        end else if (valid_i != 2'b00) begin
            id_o    = valid_i[1];
            grant_o = valid_i;
        end
    end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters: round-robin grant with an
// ownership lock for carry chains, fixed issue/wait/respond sequence.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned LOCK_MAX = 15
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    alu_arbiter_if.slave bus,
    output logic         busy_o
);
    // state | meaning
    // IDLE  | arbitrate; READY pulses and operands latch on grant
    // ISSUE | ALU_* stable, ALU samples them at the closing edge
    // WAIT  | ALU result settles, captured into RSP_* at the closing edge
    // RESP  | RSP_* held until RSP_READY, then LAST/lock update

    localparam logic [8:0] LOCK_MAX_W = 9'(LOCK_MAX);

    logic [1:0]        state_q, state_d;
    logic              id_q, id_d;
    logic              op_lock_q, op_lock_d;
    logic              last_q, last_d;
    logic              lock_q, lock_d;
    logic              owner_q, owner_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [8:0]        cnt_inc;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [FS_W-1:0]   alu_fs_q, alu_fs_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [FLAG_W-1:0] rsp_zcno_q, rsp_zcno_d;
    logic [1:0]        grant;
    logic              grant_id;

    alu_arb_rr u_rr (
        .valid_i (bus.req_valid),
        .last_i  (last_q),
        .lock_i  (lock_q),
        .owner_i (owner_q),
        .grant_o (grant),
        .id_o    (grant_id)
    );

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_comb begin
        state_d     = state_q;
        id_d        = id_q;
        op_lock_d   = op_lock_q;
        last_d      = last_q;
        lock_d      = lock_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fs_d    = alu_fs_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_zcno_d  = rsp_zcno_q;
        case (state_q)
            ST_IDLE: begin
                // An owner that stopped requesting gives up the lock at once.
                if (lock_q && !bus.req_valid[owner_q]) begin
                    lock_d = 1'b0;
                    cnt_d  = 8'd0;
                end
                if (grant != 2'b00) begin
                    id_d      = grant_id;
                    op_lock_d = bus.req_lock[grant_id];
                    alu_a_d   = bus.req_a[grant_id];
                    alu_b_d   = bus.req_b[grant_id];
                    alu_fs_d  = bus.req_funsel[grant_id];
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                rsp_data_d  = bus.alu_out;
                rsp_zcno_d  = bus.alu_zcno;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    last_d      = id_q;
                    state_d     = ST_IDLE;
                    // LAST = id makes the other requester win after a forced release.
                    if (op_lock_q && (cnt_inc < LOCK_MAX_W)) begin
                        lock_d  = 1'b1;
                        owner_d = id_q;
                        cnt_d   = cnt_inc[7:0];
                    end else begin
                        lock_d  = 1'b0;
                        cnt_d   = 8'd0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            id_q        <= 1'b0;
            op_lock_q   <= 1'b0;
            last_q      <= 1'b1;
            lock_q      <= 1'b0;
            owner_q     <= 1'b0;
            cnt_q       <= 8'd0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fs_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zcno_q  <= '0;
        end else begin
            state_q     <= state_d;
            id_q        <= id_d;
            op_lock_q   <= op_lock_d;
            last_q      <= last_d;
            lock_q      <= lock_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fs_q    <= alu_fs_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zcno_q  <= rsp_zcno_d;
        end
    end

    // READY is a combinational grant; reset gating keeps it low while rst_n is held.
    assign bus.req_ready  = (state_q == ST_IDLE) ? (grant & {2{rst_n_i}}) : 2'b00;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_zcno   = rsp_zcno_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_funsel = alu_fs_q;
    assign busy_o         = (state_q != ST_IDLE);
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer that shares one instance of the 8-bit registered `alu` (A, B, FunSel in; OutALU, ZCNO out) between independent clients. It accepts one operation at a time from a round-robin winner, drives the ALU operands, waits out the ALU's registered result and flag latency, and returns the result and flags on a single response channel. A lock bit keeps ownership across consecutive operations, so multi-byte add and rotate chains through the shared carry flag are not interleaved.

## Interface
- `LOCK_MAX`, 15: max consecutive locked operations one owner may run before the lock is force-released (1..255).
- `CLK` in 1: system clock, rising edge; same clock as `alu.CLK`.
- `RST_N` in 1: reset. One clock; reset is asynchronous and active-low.
- `REQ0_VALID` / `REQ1_VALID` in 1: requester n has an operation pending.
- `REQ0_READY` / `REQ1_READY` out 1: one-cycle accept pulse for requester n.
- `REQ0_FUNSEL` / `REQ1_FUNSEL` in 4: ALU FunSel code for requester n.
- `REQ0_A`, `REQ0_B` / `REQ1_A`, `REQ1_B` in 8 each: operands for requester n.
- `REQ0_LOCK` / `REQ1_LOCK` in 1: keep ownership after this operation.
- `RSP_VALID` out 1: response available.
- `RSP_ID` out 1: requester that owns the response.
- `RSP_DATA` out 8: captured OutALU.
- `RSP_ZCNO` out 4: captured ZCNO (Z, C, N, O).
- `RSP_READY` in 1: response consumed.
- `ALU_A`, `ALU_B` out 8: to `alu.A`, `alu.B`.
- `ALU_FUNSEL` out 4: to `alu.FunSel`.
- `ALU_OUT` in 8: from `alu.OutALU`.
- `ALU_ZCNO` in 4: from `alu.ZCNO`.
- `BUSY` out 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** pick a requester.
  - If locked, only the owner is eligible. If the owner's VALID is low, the lock clears and normal arbitration runs in the same cycle.
  - Otherwise, with both valid, grant the requester that is not `LAST`. With one valid, grant it.
  - On grant: pulse that requester's READY, latch FUNSEL/A/B into the ALU_* registers, latch the id, go to ISSUE.
- **ISSUE:** ALU_* stable. The ALU samples them at the edge that ends ISSUE. Go to WAIT.
- **WAIT:** OutALU/ZCNO settle. At the edge that ends WAIT, capture them into RSP_DATA/RSP_ZCNO, set RSP_VALID, go to RESP.
- **RESP:** hold all RSP_* stable until `RSP_READY` is high at a rising edge. Then clear RSP_VALID, set `LAST` = id, update the lock, go to IDLE.
- Lock update on response handshake:
  - If the served op had LOCK=1 and the count after increment is < `LOCK_MAX`: lock set, owner = id, count incremented.
  - Otherwise: lock cleared, count = 0.
  - On a forced release, the other requester wins the next contention.
- FunSel is passed through uninterpreted. ADD (0100) and CSR (1111) consume the ALU's stored carry, so cross-requester carry isolation relies solely on the lock.
- At most one operation is in flight. READY never asserts outside IDLE.

## Timing
- Reset values: all READY 0, RSP_VALID 0, RSP_ID 0, RSP_DATA 0x00, RSP_ZCNO 0, ALU_A/ALU_B 0x00, ALU_FUNSEL 0, BUSY 0.
- Internal reset values: state IDLE, `LAST` = 1 (requester 0 wins the first contention), lock clear, count 0.
- Latency:
  - READY pulses in cycle k.
  - RSP_VALID is high from cycle k+3.
  - With RSP_READY tied high, the next READY comes in cycle k+4. Peak throughput is 1 operation per 4 cycles.
- Simultaneous events:
  - A new REQ in RESP waits; it is not queued.
  - A REQ_VALID drop while in ISSUE/WAIT/RESP has no effect; the operation is already committed.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; the in-flight response is lost. The ALU has no reset, so its ZCNO, including carry, keeps its prior value.

## Structure
- Shared package `alu_arb_pkg`: state encoding constants, FunSel constants (`FS_A`=0000 … `FS_ADD`=0100, `FS_SUB`=0101, `FS_CMP`=0110, `FS_CSR`=1111), and ZCNO bit indices (Z=3, C=2, N=1, O=0).
- One sub-module, `alu_arb_rr`: combinational 2-way round-robin picker with lock masking. Inputs: valid[1:0], last, lock, owner. Outputs: grant one-hot, id.
- The FSM, count, and response registers stay in `alu_arbiter`.

## Test plan
- Single request: REQ0 FUNSEL=0100, A=0x05, B=0x03, carry 0 → READY0 pulses once; RSP_VALID 3 cycles later with RSP_ID=0, RSP_DATA=0x08, Z=0.
- Contention from reset: both valid → requester 0 served first, then requester 1; alternating thereafter while both stay valid.
- Lock chain: REQ1 ADD 0xFF+0x01 with LOCK=1, then ADD 0x00+0x00 with LOCK=0, REQ0 valid throughout → both REQ1 ops served back-to-back; second RSP_DATA=0x01; REQ0 served only after.
- Forced release: `LOCK_MAX`=2, REQ0 always LOCK=1, REQ1 valid → two REQ0 ops, then REQ1 granted.
- Backpressure: RSP_READY low 5 cycles → RSP_* stable; no READY pulses; BUSY=1.
- Reset in WAIT: RST_N low → all outputs at reset values asynchronously; after release, first contention goes to requester 0.
